// File: rtl/tile_dump_tx.sv
// tile_dump_tx: screen-dump reader for the text video subsystem.
// On a start tick it scans the tile RAM (port A) row by row, sends every
// character as a UART 8N1 frame and ends each row with CR LF.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   start      single-cycle dump request, accepted only when idle
//   ram_addr   tile RAM port A address {row[4:0], col[6:0]}
//   ram_data   tile RAM port A read data, one clk after ram_addr
//   tx         UART serial output, idle high
//   busy       high for the whole dump; port A belongs to this block while set
//   done_tick  one-cycle pulse when the dump completes
module tile_dump_tx #(
   parameter int unsigned MAX_X  = 40,
   parameter int unsigned MAX_Y  = 20,
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [11:0] ram_addr,
   input  logic [6:0]  ram_data,
   output logic        tx,
   output logic        busy,
   output logic        done_tick
);

   localparam int unsigned DIVISOR = CLK_HZ / BAUD;
   localparam int unsigned CntW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   localparam logic [CntW-1:0] BaudLast = CntW'(DIVISOR - 1);
   localparam logic [6:0]      ColLast  = 7'(MAX_X - 1);
   localparam logic [4:0]      RowLast  = 5'(MAX_Y - 1);

   typedef enum logic [2:0] {
      StIdle, StFetch, StLatch, StShift, StEolCr, StEolLf, StDone
   } state_e;

   // What the byte in the shifter is, so the end of its stop bit knows where to go.
   typedef enum logic [1:0] {KindChar, KindCr, KindLf} kind_e;

   state_e          state_q, state_d;
   kind_e           kind_q, kind_d;
   logic [4:0]      row_q, row_d;
   logic [6:0]      col_q, col_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [CntW-1:0] baud_q, baud_d;
   logic [7:0]      byte_q, byte_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            load;
   logic [7:0]      load_byte;
   kind_e           load_kind;

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      row_d     = row_q;
      col_d     = col_q;
      bit_cnt_d = bit_cnt_q;
      baud_d    = baud_q;
      byte_d    = byte_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load      = 1'b0;
      load_byte = 8'h00;
      load_kind = KindChar;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (start) begin
               row_d   = '0;
               col_d   = '0;
               busy_d  = 1'b1;
               state_d = StFetch;
            end
         end
         StFetch: state_d = StLatch;
         StLatch: begin
            load      = 1'b1;
            load_byte = (ram_data == 7'h00) ? 8'h20 : {1'b0, ram_data};
            load_kind = KindChar;
         end
         StShift: begin
            if (baud_q == BaudLast) begin
               baud_d    = '0;
               bit_cnt_d = 4'(bit_cnt_q + 4'd1);
               if (bit_cnt_q < 4'd8) begin
                  // bit_cnt_q = 0 is the start bit, so data bit n follows count n.
                  tx_d = byte_q[bit_cnt_q[2:0]];
               end else begin
                  tx_d = 1'b1;
                  if (bit_cnt_q == 4'd9) begin
                     unique case (kind_q)
                        KindChar: begin
                           if (col_q == ColLast) begin
                              state_d = StEolCr;
                           end else begin
                              col_d   = 7'(col_q + 7'd1);
                              state_d = StFetch;
                           end
                        end
                        KindCr: state_d = StEolLf;
                        KindLf: begin
                           if (row_q == RowLast) begin
                              busy_d  = 1'b0;
                              done_d  = 1'b1;
                              state_d = StDone;
                           end else begin
                              row_d   = 5'(row_q + 5'd1);
                              col_d   = '0;
                              state_d = StFetch;
                           end
                        end
                        default: state_d = StIdle;
                     endcase
                  end
               end
            end else begin
               baud_d = CntW'(baud_q + 1'b1);
            end
         end
         // Two-cycle pause so CR/LF keep the same gap as FETCH+LATCH; baud_q
         // is zero on entry and reused as the pause counter.
         StEolCr, StEolLf: begin
            if (baud_q == '0) begin
               baud_d = CntW'(1);
            end else begin
               load      = 1'b1;
               load_byte = (state_q == StEolCr) ? 8'h0D : 8'h0A;
               load_kind = (state_q == StEolCr) ? KindCr : KindLf;
            end
         end
         StDone: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         byte_d    = load_byte;
         kind_d    = load_kind;
         bit_cnt_d = '0;
         baud_d    = '0;
         tx_d      = 1'b0;
         state_d   = StShift;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         kind_q    <= KindChar;
         row_q     <= '0;
         col_q     <= '0;
         bit_cnt_q <= '0;
         baud_q    <= '0;
         byte_q    <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         row_q     <= row_d;
         col_q     <= col_d;
         bit_cnt_q <= bit_cnt_d;
         baud_q    <= baud_d;
         byte_q    <= byte_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign ram_addr  = {row_q, col_q};
   assign tx        = tx_q;
   assign busy      = busy_q;
   assign done_tick = done_q;

endmodule
